// File: rtl/hamming_dec_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hamming_pkg
// Purpose : Shared Hamming(12,8) definitions for the encoder and decoder.
//           Codeword layout is 1-based position p = idx+1, with parity bits at
//           the power-of-two positions (idx 0,1,3,7). The data bits d0..d7
//           occupy the remaining indices in ascending order.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package hamming_pkg;

  localparam int CODE_W = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  // Parity bit indices; bit b of the syndrome covers every position that has
  // bit b set, i.e. every position that shares a bit with PARITY_IDX[b]+1.
  localparam int P0_IDX = 0;
  localparam int P1_IDX = 1;
  localparam int P3_IDX = 3;
  localparam int P7_IDX = 7;
  localparam int PARITY_IDX [SYN_W] = '{P0_IDX, P1_IDX, P3_IDX, P7_IDX};

  // Data bit d[i] lives at codeword index DATA_IDX[i].
  localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  // Syndrome {s7,s3,s1,s0}: non-zero value is the 1-based position of a
  // single flipped bit.
  function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] s;
    s = '0;
    for (int b = 0; b < SYN_W; b++) begin
      for (int i = 0; i < CODE_W; i++) begin
        if (((i + 1) & (PARITY_IDX[b] + 1)) != 0) begin
          s[b] = s[b] ^ code[i];
        end
      end
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = code[DATA_IDX[i]];
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_dec_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : hamming_dec_pipe_if
// Purpose : Input and output valid/ready channels of the Hamming decoder.
// Ports   : i_valid/o_ready/i_code      - codeword channel into the decoder
//           o_valid/i_ready/o_data/o_syndrome/o_corrected/o_uncorr
//                                       - result channel out of the decoder
//           modport slave  : decoder side
//           modport master : producer/consumer side
// Rev     : 1.0  initial release
// ============================================================================
interface hamming_dec_pipe_if;
  import hamming_pkg::*;

  logic              i_valid;
  logic              o_ready;
  logic [CODE_W-1:0] i_code;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [SYN_W-1:0]  o_syndrome;
  logic              o_corrected;
  logic              o_uncorr;

  modport slave (
    input  i_valid, i_code, i_ready,
    output o_ready, o_valid, o_data, o_syndrome, o_corrected, o_uncorr
  );

  modport master (
    output i_valid, i_code, i_ready,
    input  o_ready, o_valid, o_data, o_syndrome, o_corrected, o_uncorr
  );

endinterface
`default_nettype wire

// File: rtl/hamming_dec_pipe_syndrome.sv
`default_nettype none
// ============================================================================
// Module  : hamming_syndrome
// Purpose : Combinational syndrome generator, codeword -> {s7,s3,s1,s0}.
// Ports   : i_code - 12-bit codeword
//           o_syn  - 4-bit syndrome
// Rev     : 1.0  initial release
// ============================================================================
module hamming_syndrome
  import hamming_pkg::*;
(
  input  wire logic [CODE_W-1:0] i_code,
  output logic      [SYN_W-1:0]  o_syn
);

  assign o_syn = syndrome(i_code);

endmodule
`default_nettype wire

// File: rtl/hamming_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module  : hamming_dec_pipe
// Purpose : Two-stage pipelined Hamming(12,8) SEC decoder with valid/ready on
//           both sides and saturating corrected/uncorrectable event counters.
//           S1 registers the codeword and its syndrome; S2 registers the
//           corrected data and flags.
// Ports   : i_clk, i_rst_n  - clock, async active-low reset
//           bus (slave)     - codeword in / decoded result out
//           i_clr_cnt       - synchronous clear of both counters
//           o_corr_cnt      - accepted words with a corrected error
//           o_uncorr_cnt    - accepted words with an uncorrectable syndrome
// Rev     : 1.0  initial release
// ============================================================================
module hamming_dec_pipe
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  hamming_dec_pipe_if.slave      bus,
  input  wire logic              i_clr_cnt,
  output logic      [CNT_W-1:0]  o_corr_cnt,
  output logic      [CNT_W-1:0]  o_uncorr_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic              r_s1_valid;
  logic [CODE_W-1:0] r_s1_code;
  logic [SYN_W-1:0]  r_s1_syn;
  logic [SYN_W-1:0]  w_syn;

  logic              r_o_valid;
  logic [DATA_W-1:0] r_o_data;
  logic [SYN_W-1:0]  r_o_syn;
  logic              r_o_corr;
  logic              r_o_uncorr;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_uncorr_cnt;

  logic              w_accept;
  logic              w_s2_load;
  logic              w_out_fire;
  logic              w_fix_en;
  logic              w_uncorr;
  logic [CODE_W-1:0] w_flip;
  logic [DATA_W-1:0] w_fixed_data;

  hamming_syndrome u_syn (
    .i_code (bus.i_code),
    .o_syn  (w_syn)
  );

  // S2 can take S1's word when it is empty or its word leaves this cycle, so
  // a word can enter S1 in the same cycle S1 drains: no bubbles at full rate.
  assign w_s2_load   = r_s1_valid && (!r_o_valid || bus.i_ready);
  assign bus.o_ready = !r_s1_valid || w_s2_load;
  assign w_accept    = bus.i_valid && bus.o_ready;
  assign w_out_fire  = r_o_valid && bus.i_ready;

  // Syndromes 1..12 name a real bit; 13..15 point outside the codeword.
  assign w_fix_en     = (r_s1_syn != '0) && (r_s1_syn <= SYN_W'(CODE_W));
  assign w_uncorr     = (r_s1_syn >  SYN_W'(CODE_W));
  assign w_flip       = w_fix_en ? (CODE_W'(1) << (r_s1_syn - SYN_W'(1))) : '0;
  assign w_fixed_data = extract_data(r_s1_code ^ w_flip);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_code  <= bus.i_code;
      r_s1_syn   <= w_syn;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_o_syn    <= '0;
      r_o_corr   <= 1'b0;
      r_o_uncorr <= 1'b0;
    end else if (w_s2_load) begin
      r_o_valid  <= 1'b1;
      r_o_data   <= w_fixed_data;
      r_o_syn    <= r_s1_syn;
      r_o_corr   <= w_fix_en;
      r_o_uncorr <= w_uncorr;
    end else if (bus.i_ready) begin
      r_o_valid  <= 1'b0;
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (i_clr_cnt) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_out_fire && r_o_corr && (r_corr_cnt != C_CNT_MAX)) begin
        r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      end
      if (w_out_fire && r_o_uncorr && (r_uncorr_cnt != C_CNT_MAX)) begin
        r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.o_valid     = r_o_valid;
  assign bus.o_data      = r_o_data;
  assign bus.o_syndrome  = r_o_syn;
  assign bus.o_corrected = r_o_corr;
  assign bus.o_uncorr    = r_o_uncorr;
  assign o_corr_cnt      = r_corr_cnt;
  assign o_uncorr_cnt    = r_uncorr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hamming_dec_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_hamming_dec_pipe
// Purpose : Self-checking bench for hamming_dec_pipe (counters at 4 bits).
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_hamming_dec_pipe;

  localparam int CNT_W = 4;

  typedef struct {
    logic [11:0] code;
    logic [7:0]  data;
    logic [3:0]  syn;
    logic        corr;
    logic        uncorr;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr_cnt;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t vecs[$];
  logic [11:0] bs_code [4];
  logic [7:0]  bs_data [4];

  hamming_dec_pipe_if bus ();

  hamming_dec_pipe #(.CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .bus          (bus.slave),
    .i_clr_cnt    (clr_cnt),
    .o_corr_cnt   (corr_cnt),
    .o_uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=0x%0h req=0x%0h", nm, act, exp);
    end
  endtask

  // One word with i_ready high; expects o_valid on the 2nd edge after accept.
  task automatic apply_vec(input vec_t v, input string nm);
    int lat;
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_code  = v.code;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.o_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 2);
    chk({nm, "_data"},    bus.o_data, v.data);
    chk({nm, "_syn"},     bus.o_syndrome, v.syn);
    chk({nm, "_corr"},    bus.o_corrected, v.corr);
    chk({nm, "_uncorr"},  bus.o_uncorr, v.uncorr);
  endtask

  task automatic clear_counters();
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  // Streams the 4 bs_code words; i_ready held low for the first 'stall' cycles.
  task automatic run_stream(input int stall, input string nm);
    logic [7:0] rx[$];
    int k;
    int low_seen;
    logic acc;
    k = 0;
    low_seen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus.i_ready = (cyc >= stall);
      bus.i_valid = (k < 4);
      if (k < 4) bus.i_code = bs_code[k];
      #1;
      if (!bus.o_ready) low_seen++;
      if (stall > 0 && cyc == 3) begin
        chk({nm, "_accepted_when_full"}, k, 2);
        chk({nm, "_ready_low_when_full"}, bus.o_ready, 1'b0);
        chk({nm, "_held_valid"}, bus.o_valid, 1'b1);
        chk({nm, "_held_data"}, bus.o_data, bs_data[0]);
      end
      if (stall == 0 && cyc == 4) chk({nm, "_accepted_back_to_back"}, k, 4);
      if (stall == 0 && cyc == 6) chk({nm, "_out_back_to_back"}, rx.size(), 4);
      if (bus.o_valid && bus.i_ready) rx.push_back(bus.o_data);
      acc = bus.i_valid && bus.o_ready;
      @(posedge clk);
      if (acc) k++;
    end
    bus.i_valid = 1'b0;
    chk({nm, "_ready_dropped"}, (low_seen != 0), (stall != 0));
    chk({nm, "_out_count"}, rx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx.size()) chk($sformatf("%s_out%0d", nm, i), rx[i], bs_data[i]);
    end
  endtask

  initial begin
    vec_t v;
    logic [11:0] clean;
    int seen;

    bus.i_valid = 1'b0;
    bus.i_code  = '0;
    bus.i_ready = 1'b0;
    clr_cnt     = 1'b0;

    // Directed vectors (hand-computed) plus every single-bit flip of 12'hA27.
    vecs.push_back('{12'hA27, 8'hA5, 4'd0,  1'b0, 1'b0});
    vecs.push_back('{12'hA07, 8'hA5, 4'd6,  1'b1, 1'b0});
    vecs.push_back('{12'h226, 8'h25, 4'd13, 1'b0, 1'b1});
    vecs.push_back('{12'h000, 8'h00, 4'd0,  1'b0, 1'b0});
    vecs.push_back('{12'hFFF, 8'h7F, 4'd12, 1'b1, 1'b0});
    vecs.push_back('{12'h802, 8'h80, 4'd14, 1'b0, 1'b1});
    vecs.push_back('{12'h804, 8'h81, 4'd15, 1'b0, 1'b1});
    clean = 12'hA27;
    for (int i = 0; i < 12; i++) begin
      v.code   = clean ^ (12'h001 << i);
      v.data   = 8'hA5;
      v.syn    = 4'(i + 1);
      v.corr   = 1'b1;
      v.uncorr = 1'b0;
      vecs.push_back(v);
    end

    bs_code = '{12'hA27, 12'h000, 12'h226, 12'hFFF};
    bs_data = '{8'hA5,   8'h00,   8'h25,   8'h7F};

    // Reset state
    #12;
    chk("rst_o_valid", bus.o_valid, 1'b0);
    chk("rst_o_data", bus.o_data, 8'h00);
    chk("rst_o_syn", bus.o_syndrome, 4'd0);
    chk("rst_flags", {bus.o_corrected, bus.o_uncorr}, 2'b00);
    chk("rst_counters", {corr_cnt, uncorr_cnt}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_o_ready", bus.o_ready, 1'b1);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Counter increments per flag
    clear_counters();
    #1;
    chk("cnt_after_clr", {corr_cnt, uncorr_cnt}, 8'h00);
    apply_vec(vecs[0], "cnt_clean");
    @(negedge clk); #1;
    chk("cnt_clean_corr", corr_cnt, 4'd0);
    apply_vec(vecs[1], "cnt_1bit");
    @(negedge clk); #1;
    chk("cnt_1bit_corr", corr_cnt, 4'd1);
    chk("cnt_1bit_uncorr", uncorr_cnt, 4'd0);
    apply_vec(vecs[2], "cnt_unc");
    @(negedge clk); #1;
    chk("cnt_unc_uncorr", uncorr_cnt, 4'd1);
    chk("cnt_unc_corr", corr_cnt, 4'd1);

    // Full throughput and back-pressure
    run_stream(0, "stream");
    run_stream(5, "bp");

    // Saturation: 20 corrected words into a 4-bit counter
    clear_counters();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_code  = 12'hA07;
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("sat_corr_cnt", corr_cnt, 4'd15);
    chk("sat_uncorr_cnt", uncorr_cnt, 4'd0);

    // Clear coincident with an increment
    clear_counters();
    apply_vec(vecs[1], "clr_pre");
    @(negedge clk); #1;
    chk("clr_pre_cnt", corr_cnt, 4'd1);
    apply_vec(vecs[1], "clr_race");
    clr_cnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_cnt = 1'b0;
    #1;
    chk("clr_wins_cnt", corr_cnt, 4'd0);

    // Async reset with both stages full
    apply_vec(vecs[1], "ar_pre");
    @(negedge clk);
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_code  = 12'hA07;
    @(posedge clk);
    @(negedge clk);
    bus.i_code  = 12'h226;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1;
    chk("ar_full_valid", bus.o_valid, 1'b1);
    chk("ar_full_ready", bus.o_ready, 1'b0);
    chk("ar_pre_cnt", corr_cnt, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_o_valid", bus.o_valid, 1'b0);
    chk("ar_counters", {corr_cnt, uncorr_cnt}, 8'h00);
    chk("ar_o_ready", bus.o_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus.o_valid) seen++;
    end
    chk("ar_no_output_after", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
